// File: rtl/prio_pkg.sv
// Shared types and default sizes for the priority result selector.
package prio_pkg;

  typedef enum logic [1:0] {
    VACIO   = 2'd0,
    RETENER = 2'd1,
    MOSTRAR = 2'd2
  } state_t;

  localparam int N_CH_DEF     = 3;
  localparam int W_IN_DEF     = 16;
  localparam int HOLD_CYC_DEF = 4;

endpackage

// File: rtl/prio_captura.sv
// One channel of the selector: listo rise detect, valid flag and value capture.
// With PRIO_SIGN_EN defined the channel sign is captured alongside the value.
module prio_captura #(
  parameter int W_IN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            listo,
  input  logic [W_IN-1:0] num,
`ifdef PRIO_SIGN_EN
  input  logic            sig,
  output logic            cap_sig,
`endif
  output logic            flag,
  output logic [W_IN-1:0] cap
);

  logic prev;
  logic rise;

  assign rise = listo & ~prev;

  // prev tracks listo even during clr so a level held across clr never retriggers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= 1'b0;
      flag    <= 1'b0;
      cap     <= '0;
`ifdef PRIO_SIGN_EN
      cap_sig <= 1'b0;
`endif
    end else begin
      prev <= listo;
      if (clr) begin
        flag    <= 1'b0;
        cap     <= '0;
`ifdef PRIO_SIGN_EN
        cap_sig <= 1'b0;
`endif
      end else if (rise) begin
        flag    <= 1'b1;
        cap     <= num;
`ifdef PRIO_SIGN_EN
        cap_sig <= sig;
`endif
      end
    end
  end

endmodule

// File: rtl/prio_sel_n.sv
// N-channel priority result selector with minimum display hold.
// Optional sign path is enabled by defining PRIO_SIGN_EN.
module prio_sel_n
  import prio_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int W_IN     = W_IN_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*W_IN-1:0] num_in,
  input  logic [N_CH-1:0]      listo_in,
  input  logic                 clr,
  output logic [W_IN-1:0]      numero_output,
  output logic [CHW-1:0]       canal_output,
  output logic                 valido,
  output logic                 cambio,
  output state_t               estado
`ifdef PRIO_SIGN_EN
  ,
  input  logic [N_CH-1:0]      sig_in,
  output logic                 signo_output
`endif
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  logic [N_CH-1:0] flag;
  logic [W_IN-1:0] cap [N_CH];
  logic [CHW-1:0]  win_idx;
  logic [W_IN-1:0] win_val;
  logic            any_flag;
  logic            sign_diff;
  logic            changed;
  logic            load_now;
  logic [CW-1:0]   cnt;
  state_t          state;

`ifdef PRIO_SIGN_EN
  logic [N_CH-1:0] cap_sig;
  logic            win_sig;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    prio_captura #(.W_IN(W_IN)) u_cap (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .listo  (listo_in[g]),
      .num    (num_in[g*W_IN +: W_IN]),
`ifdef PRIO_SIGN_EN
      .sig    (sig_in[g]),
      .cap_sig(cap_sig[g]),
`endif
      .flag   (flag[g]),
      .cap    (cap[g])
    );
  end

  // Ascending scan: the last flagged channel seen is the highest priority.
  always_comb begin
    win_idx  = '0;
    win_val  = '0;
    any_flag = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (flag[i]) begin
        win_idx  = CHW'(i);
        win_val  = cap[i];
        any_flag = 1'b1;
      end
    end
  end

`ifdef PRIO_SIGN_EN
  always_comb begin
    win_sig = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (flag[i]) win_sig = cap_sig[i];
    end
  end
  assign sign_diff = (win_sig != signo_output);
`else
  assign sign_diff = 1'b0;
`endif

  assign changed  = (win_idx != canal_output) || (win_val != numero_output) || sign_diff;

  // The last hold cycle doubles as the first MOSTRAR compare so the hold is exactly HOLD_CYC edges.
  assign load_now = !clr && any_flag &&
                    ((state == VACIO) ||
                     (state == RETENER && cnt == '0 && changed) ||
                     (state == MOSTRAR && changed));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= VACIO;
      cnt           <= '0;
      numero_output <= '0;
      canal_output  <= '0;
      valido        <= 1'b0;
      cambio        <= 1'b0;
`ifdef PRIO_SIGN_EN
      signo_output  <= 1'b0;
`endif
    end else begin
      cambio <= 1'b0;
      if (clr) begin
        state         <= VACIO;
        cnt           <= '0;
        numero_output <= '0;
        canal_output  <= '0;
        valido        <= 1'b0;
`ifdef PRIO_SIGN_EN
        signo_output  <= 1'b0;
`endif
      end else if (load_now) begin
        numero_output <= win_val;
        canal_output  <= win_idx;
        valido        <= 1'b1;
        cambio        <= 1'b1;
`ifdef PRIO_SIGN_EN
        signo_output  <= win_sig;
`endif
        if (HOLD_CYC > 0) begin
          state <= RETENER;
          cnt   <= CNT_INIT;
        end else begin
          state <= MOSTRAR;
        end
      end else if (state == RETENER) begin
        if (cnt == '0) state <= MOSTRAR;
        else           cnt   <= cnt - CW'(1);
      end
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_prio_sel_n.sv
// Directed and random checks of prio_sel_n against an edge-level reference model.
module tb_prio_sel_n;
  import prio_pkg::*;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int H   = 4;
  localparam int CHW = 2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] num_in;
  logic [N-1:0]   listo_in;
  logic           clr;
  logic [W-1:0]   numero_output;
  logic [CHW-1:0] canal_output;
  logic           valido;
  logic           cambio;
  state_t         estado;
`ifdef PRIO_SIGN_EN
  logic [N-1:0]   sig_in;
  logic           signo_output;
`endif

  prio_sel_n #(.N_CH(N), .W_IN(W), .HOLD_CYC(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .num_in       (num_in),
    .listo_in     (listo_in),
    .clr          (clr),
    .numero_output(numero_output),
    .canal_output (canal_output),
    .valido       (valido),
    .cambio       (cambio),
    .estado       (estado)
`ifdef PRIO_SIGN_EN
    ,
    .sig_in       (sig_in),
    .signo_output (signo_output)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: per-channel flags and captured values, plus what is on display
  logic [N-1:0]   m_prev;
  logic [N-1:0]   m_flag;
  logic [W-1:0]   m_cap [N];
  logic [N-1:0]   m_csig;
  logic [W-1:0]   m_val;
  logic [CHW-1:0] m_ch;
  logic           m_valid;
  logic           m_cambio;
  logic           m_sign;
  int             m_last;
  int             edge_n;

  task automatic model_reset();
    m_prev = '0; m_flag = '0; m_csig = '0;
    for (int i = 0; i < N; i++) m_cap[i] = '0;
    m_val = '0; m_ch = '0; m_valid = 1'b0; m_cambio = 1'b0; m_sign = 1'b0;
    m_last = 0; edge_n = 0;
  endtask

  task automatic model_edge();
    int  w;
    logic s_in;
    w = -1;
    for (int i = 0; i < N; i++) if (m_flag[i]) w = i;
    m_cambio = 1'b0;
    if (clr) begin
      m_valid = 1'b0; m_val = '0; m_ch = '0; m_sign = 1'b0;
    end else if (w >= 0 && (!m_valid || edge_n - m_last >= H)) begin
      if (!m_valid || w != int'(m_ch) || m_cap[w] != m_val || m_csig[w] != m_sign) begin
        m_valid = 1'b1; m_val = m_cap[w]; m_ch = CHW'(w); m_sign = m_csig[w];
        m_last = edge_n; m_cambio = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
`ifdef PRIO_SIGN_EN
      s_in = sig_in[i];
`else
      s_in = 1'b0;
`endif
      if (clr) begin
        m_flag[i] = 1'b0; m_cap[i] = '0; m_csig[i] = 1'b0;
      end else if (listo_in[i] && !m_prev[i]) begin
        m_flag[i] = 1'b1; m_cap[i] = num_in[i*W +: W]; m_csig[i] = s_in;
      end
      m_prev[i] = listo_in[i];
    end
    edge_n++;
  endtask

  // scoreboard compare of every output against the model
  task automatic check(string tag);
    n_assert++;
    assert (numero_output === m_val) else begin
      n_fail++; $error("FAIL %s numero observed=%0d expected=%0d", tag, numero_output, m_val);
    end
    n_assert++;
    assert (canal_output === m_ch) else begin
      n_fail++; $error("FAIL %s canal observed=%0d expected=%0d", tag, canal_output, m_ch);
    end
    n_assert++;
    assert (valido === m_valid) else begin
      n_fail++; $error("FAIL %s valido observed=%0b expected=%0b", tag, valido, m_valid);
    end
    n_assert++;
    assert (cambio === m_cambio) else begin
      n_fail++; $error("FAIL %s cambio observed=%0b expected=%0b", tag, cambio, m_cambio);
    end
    if (!m_valid) begin
      n_assert++;
      assert (estado === VACIO) else begin
        n_fail++; $error("FAIL %s estado observed=%0d expected=%0d", tag, estado, VACIO);
      end
    end
`ifdef PRIO_SIGN_EN
    n_assert++;
    assert (signo_output === m_sign) else begin
      n_fail++; $error("FAIL %s signo observed=%0b expected=%0b", tag, signo_output, m_sign);
    end
`endif
  endtask

  // driver tasks
  task automatic step(string tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check(tag);
  endtask

  task automatic steps(int n, string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic set_ch(int ch, logic [W-1:0] v, logic lv, logic s);
    num_in[ch*W +: W] = v;
    listo_in[ch]      = lv;
`ifdef PRIO_SIGN_EN
    sig_in[ch]        = s;
`else
    if (s) num_in[ch*W +: W] = v;
`endif
  endtask

  task automatic quiet();
    listo_in = '0;
    clr      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; listo_in = '0; num_in = '0;
`ifdef PRIO_SIGN_EN
    sig_in = '0;
`endif
    model_reset();

    // reset held with random inputs: every output stays zero
    for (int k = 0; k < 6; k++) begin
      num_in   = {$urandom, $urandom};
      listo_in = N'($urandom_range(0, 7));
      clr      = 1'(($urandom_range(0, 1)));
      @(posedge clk); #1;
      model_reset();
      check("reset_hold");
    end
    quiet();
    @(negedge clk) rst = 1'b1;
    steps(2, "idle");

    // sequential fill: 15, then 10 after the hold, then 150
    set_ch(0, 16'd15, 1'b1, 1'b0);
    steps(2, "fill_a");
    set_ch(1, 16'd10, 1'b1, 1'b0);
    steps(6, "fill_b");
    set_ch(2, 16'd150, 1'b1, 1'b0);
    steps(8, "fill_c");
    n_assert++;
    assert (numero_output === 16'd150 && canal_output === 2'd2) else begin
      n_fail++; $error("FAIL fill_final observed=%0d/%0d expected=150/2", numero_output, canal_output);
    end

    // priority: a lower channel capture does not displace channel 2
    set_ch(0, 16'd0, 1'b0, 1'b0);
    step("prio_a");
    set_ch(0, 16'd99, 1'b1, 1'b0);
    steps(8, "prio_b");

    clr = 1'b1; step("clr_a");
    quiet(); steps(2, "clr_b");

    // hold masking: 15 shown for exactly H cycles, then 150
    set_ch(0, 16'd15, 1'b1, 1'b0);
    step("mask_a");
    set_ch(2, 16'd150, 1'b1, 1'b0);
    steps(H + 3, "mask_b");

    // clear during the hold with a simultaneous ch1 rise
    clr = 1'b1; step("clr_c");
    quiet(); step("clr_d");
    set_ch(0, 16'd15, 1'b1, 1'b0);
    steps(2, "hold_a");
    clr = 1'b1;
    set_ch(1, 16'd77, 1'b1, 1'b0);
    step("clr_rise");
    clr = 1'b0;
    steps(6, "clr_after");
    n_assert++;
    assert (valido === 1'b0 && numero_output === '0) else begin
      n_fail++; $error("FAIL clr_ch1_unflagged observed=%0b/%0d expected=0/0", valido, numero_output);
    end

    // asynchronous reset in the middle of a hold
    quiet(); step("ar_a");
    set_ch(2, 16'd150, 1'b1, 1'b0);
    steps(2, "ar_b");
    #2 rst = 1'b0;
    #1 model_reset();
    check("async_reset");
    @(negedge clk) rst = 1'b1;
    steps(H + 3, "ar_restart");

`ifdef PRIO_SIGN_EN
    // sign-only change in MOSTRAR counts as a new value
    clr = 1'b1; step("sg_a");
    quiet(); step("sg_b");
    set_ch(2, 16'd150, 1'b1, 1'b1);
    steps(2, "sg_c");
    set_ch(2, 16'd150, 1'b0, 1'b1);
    step("sg_d");
    set_ch(2, 16'd150, 1'b1, 1'b0);
    steps(H + 3, "sg_e");
`endif

    // random traffic with occasional clears
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) listo_in[i] = ~listo_in[i];
        num_in[i*W +: W] = W'($urandom_range(0, 3));
`ifdef PRIO_SIGN_EN
        sig_in[i] = 1'($urandom_range(0, 1));
`endif
      end
      clr = ($urandom_range(0, 29) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
